// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the audio-codec I2C configuration sequencer.
// Holds the FSM state encoding, the WM8731 register map and the layout of a
// table word (7-bit register address followed by 9-bit register data).
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_H_ISSUE,
        S_H_WAIT,
        S_ERR
    } state_t;

    // WM8731 register addresses
    localparam logic [6:0] R_LLIN   = 7'h00;
    localparam logic [6:0] R_RLIN   = 7'h01;
    localparam logic [6:0] R_LHPOUT = 7'h02;
    localparam logic [6:0] R_RHPOUT = 7'h03;
    localparam logic [6:0] R_APATH  = 7'h04;
    localparam logic [6:0] R_DPATH  = 7'h05;
    localparam logic [6:0] R_POWER  = 7'h06;
    localparam logic [6:0] R_DAIF   = 7'h07;
    localparam logic [6:0] R_SRATE  = 7'h08;
    localparam logic [6:0] R_ACTIVE = 7'h09;
    localparam logic [6:0] R_RESET  = 7'h0F;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] data;
    } cfg_word_t;

    function automatic cfg_word_t mk_word(input logic [6:0] a, input logic [8:0] d);
        cfg_word_t w;
        w.reg_addr = a;
        w.data     = d;
        return w;
    endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Fixed codec configuration table: maps a table index to the 16-bit
// {reg, data} word. Indices past the populated entries read as zero.
module i2c_cfg_rom
    import i2c_cfg_pkg::*;
(
    input  logic [4:0]  idx,
    output logic [15:0] word
);

    cfg_word_t w;

    // Table lookup: reset, power, line-in L/R, HP-out L/R, paths, format, rate, active
    always_comb begin
        case (idx)
            5'd0:    w = mk_word(R_RESET,  9'h000);
            5'd1:    w = mk_word(R_POWER,  9'h000);
            5'd2:    w = mk_word(R_LLIN,   9'h017);
            5'd3:    w = mk_word(R_RLIN,   9'h017);
            5'd4:    w = mk_word(R_LHPOUT, 9'h079);
            5'd5:    w = mk_word(R_RHPOUT, 9'h079);
            5'd6:    w = mk_word(R_APATH,  9'h012);
            5'd7:    w = mk_word(R_DPATH,  9'h000);
            5'd8:    w = mk_word(R_DAIF,   9'h042);
            5'd9:    w = mk_word(R_SRATE,  9'h000);
            5'd10:   w = mk_word(R_ACTIVE, 9'h001);
            default: w = '0;
        endcase
    end

    assign word = w;

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Codec configuration sequencer in front of a shared I2C bit engine.
// Walks the configuration table after reset (after a settle delay) or on
// cfg_go, and slots single host writes in at word boundaries.
// Optional feature macro: I2C_CFG_RETRY_EN (retry NACKed table words up to
// MAX_RETRY times before flagging cfg_error).
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         NUM_REGS    = 11,
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter int         SETTLE_CYC  = 50000,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        cfg_go,
    output logic [23:0] i2c_data,
    output logic        i2c_start,
    input  logic        i2c_end,
    input  logic        i2c_nack,
    input  logic        host_req,
    input  logic [23:0] host_data,
    output logic        host_ack,
    output logic        host_err,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [4:0]  cfg_idx
);

    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int WD_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int WD_W   = (WD_RAW > 17) ? WD_RAW : 17;

    if (NUM_REGS < 1 || NUM_REGS > 32 || SETTLE_CYC < 1 || TIMEOUT_CYC < 2 || MAX_RETRY < 0)
    begin : g_param_check
        $error("i2c_cfg_sequencer: parameter out of range");
    end

    state_t            state, next_state;
    logic [SET_W-1:0]  settle_cnt, settle_nxt;
    logic [WD_W-1:0]   wdog, wdog_nxt;
    logic              go_pend, go_pend_nxt;
    logic [23:0]       data_nxt;
    logic [4:0]        idx_nxt;
    logic              start_nxt, ack_nxt, herr_nxt, busy_nxt, done_nxt, error_nxt;
    logic [15:0]       rom_word;
    logic              host_take, settle_done, wd_expire, last_word, retry_ok;
    logic              xfer_end, restart_req;

    i2c_cfg_rom u_rom (
        .idx  (cfg_idx),
        .word (rom_word)
    );

    // host_ack masks the request for one cycle so a host that drops
    // host_req in response to the ack is never served twice
    assign host_take   = host_req & ~host_ack;
    assign settle_done = (settle_cnt == SET_W'(SETTLE_CYC - 1));
    // start drops on the edge where the watchdog reaches TIMEOUT_CYC
    assign wd_expire   = ~i2c_end & (wdog == WD_W'(TIMEOUT_CYC - 1));
    assign xfer_end    = i2c_end | wd_expire;
    assign last_word   = (cfg_idx == 5'(NUM_REGS - 1));
    assign restart_req = go_pend | (cfg_go & ~cfg_busy);

`ifdef I2C_CFG_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0] retry_cnt;

    assign retry_ok = (int'(retry_cnt) < MAX_RETRY);

    // Per-word NACK retry count, cleared whenever a new word is loaded
    always_ff @(posedge clk_50) begin
        if (!reset_n || state == S_LOAD)
            retry_cnt <= '0;
        else if (state == S_WAIT && i2c_end && i2c_nack && retry_ok)
            retry_cnt <= retry_cnt + 1'b1;
    end
`else
    assign retry_ok = 1'b0;
`endif

    // State register; reset always restarts the automatic configuration
    always_ff @(posedge clk_50) begin
        if (!reset_n) state <= S_SETTLE;
        else          state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_SETTLE:  if (settle_done) next_state = S_LOAD;
            S_LOAD:    next_state = host_take ? S_H_ISSUE : S_ISSUE;
            S_ISSUE:   if (!i2c_end) next_state = S_WAIT;
            S_WAIT: begin
                if (i2c_end)        next_state = i2c_nack ? (retry_ok ? S_ISSUE : S_ERR) : S_NEXT;
                else if (wd_expire) next_state = S_ERR;
            end
            S_NEXT:    next_state = last_word ? S_IDLE : S_LOAD;
            S_IDLE: begin
                if (host_take)   next_state = S_H_ISSUE;
                else if (cfg_go) next_state = S_LOAD;
            end
            S_H_ISSUE: if (!i2c_end) next_state = S_H_WAIT;
            S_H_WAIT:  if (xfer_end) next_state = (cfg_busy | restart_req) ? S_LOAD : S_IDLE;
            S_ERR:     next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and counters
    always_comb begin
        settle_nxt  = settle_cnt;
        wdog_nxt    = wdog;
        go_pend_nxt = go_pend;
        data_nxt    = i2c_data;
        idx_nxt     = cfg_idx;
        start_nxt   = i2c_start;
        ack_nxt     = 1'b0;
        herr_nxt    = 1'b0;
        done_nxt    = cfg_done;
        error_nxt   = cfg_error;
        case (state)
            S_SETTLE: begin
                settle_nxt = settle_cnt + 1'b1;
                if (settle_done) idx_nxt = '0;
            end
            S_LOAD: begin
                if (host_take) data_nxt = host_data;
                else           data_nxt = {DEV_ADDR, rom_word};
            end
            S_ISSUE, S_H_ISSUE: begin
                if (!i2c_end) begin
                    start_nxt = 1'b1;
                    wdog_nxt  = '0;
                end
                if (state == S_H_ISSUE) go_pend_nxt = restart_req;
            end
            S_WAIT, S_H_WAIT: begin
                if (wdog != '1) wdog_nxt = wdog + 1'b1;
                if (xfer_end) start_nxt = 1'b0;
                if (state == S_H_WAIT) begin
                    go_pend_nxt = restart_req;
                    if (xfer_end) begin
                        ack_nxt     = 1'b1;
                        herr_nxt    = i2c_end ? i2c_nack : 1'b1;
                        go_pend_nxt = 1'b0;
                        if (restart_req) begin
                            idx_nxt   = '0;
                            done_nxt  = 1'b0;
                            error_nxt = 1'b0;
                        end
                    end
                end
            end
            S_NEXT: begin
                if (last_word) done_nxt = 1'b1;
                else           idx_nxt  = cfg_idx + 5'd1;
            end
            S_IDLE: begin
                if (host_take) begin
                    data_nxt    = host_data;
                    go_pend_nxt = cfg_go;
                end else if (cfg_go) begin
                    idx_nxt   = '0;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                end
            end
            S_ERR:   error_nxt = 1'b1;
            default: ;
        endcase
    end

    // Busy covers the table states; a host transfer inherits the table's status
    always_comb begin
        case (next_state)
            S_SETTLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT: busy_nxt = 1'b1;
            S_H_ISSUE, S_H_WAIT:                       busy_nxt = cfg_busy;
            default:                                   busy_nxt = 1'b0;
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            wdog       <= '0;
            go_pend    <= 1'b0;
            i2c_data   <= '0;
            i2c_start  <= 1'b0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            cfg_idx    <= '0;
        end else begin
            settle_cnt <= settle_nxt;
            wdog       <= wdog_nxt;
            go_pend    <= go_pend_nxt;
            i2c_data   <= data_nxt;
            i2c_start  <= start_nxt;
            host_ack   <= ack_nxt;
            host_err   <= herr_nxt;
            cfg_busy   <= busy_nxt;
            cfg_done   <= done_nxt;
            cfg_error  <= error_nxt;
            cfg_idx    <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: a scenario table (reset run, NACK,
// timeout, re-run) plus hand sequences for host arbitration and mid-transfer
// reset. A simple I2C master model acks each transfer after ACK_DLY cycles.
module tb_i2c_cfg_sequencer;

    localparam int NREG    = 11;
    localparam int SETTLE  = 10;
    localparam int TMO     = 64;
    localparam int ACK_DLY = 20;
`ifdef I2C_CFG_RETRY_EN
    localparam int NACK_STARTS = 7;
`else
    localparam int NACK_STARTS = 4;
`endif

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_go = 1'b0;
    logic        i2c_end = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        host_req = 1'b0;
    logic [23:0] host_data = '0;
    logic [23:0] i2c_data;
    logic        i2c_start, host_ack, host_err, cfg_busy, cfg_done, cfg_error;
    logic [4:0]  cfg_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int first_rise = -1;
    int rise_cyc = 0;
    int last_dur = 0;
    int ack_cnt = 0;
    bit hang = 0;
    bit nack_en = 0;
    bit h_ok, h_err;
    logic [23:0] nack_word = '0;
    logic [23:0] log_q[$];
    logic [15:0] exp_rom [NREG] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                     16'h0812, 16'h0A00, 16'h0E42, 16'h1000, 16'h1201};

    typedef struct {
        string       name;
        bit          use_reset;
        bit          nack_en;
        logic [23:0] nack_word;
        bit          hang;
        int          exp_starts;
        int          n_chk;
        bit          exp_done;
        bit          exp_err;
        int          exp_idx;
    } scen_t;
    scen_t sc[4];

    i2c_cfg_sequencer #(
        .NUM_REGS(NREG), .DEV_ADDR(8'h34), .SETTLE_CYC(SETTLE),
        .TIMEOUT_CYC(TMO), .MAX_RETRY(3)
    ) dut (
        .clk_50(clk_50), .reset_n(reset_n), .cfg_go(cfg_go),
        .i2c_data(i2c_data), .i2c_start(i2c_start), .i2c_end(i2c_end), .i2c_nack(i2c_nack),
        .host_req(host_req), .host_data(host_data), .host_ack(host_ack), .host_err(host_err),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .cfg_idx(cfg_idx)
    );

    always #5 clk_50 = ~clk_50;

    initial forever begin
        @(posedge clk_50);
        cyc++;
    end

    // Transfer monitor: logs the data word at each start rise and start width
    initial begin : mon
        logic start_q;
        start_q = 1'b0;
        forever begin
            @(negedge clk_50);
            if (i2c_start && !start_q) begin
                log_q.push_back(i2c_data);
                rise_cyc = cyc;
                if (first_rise < 0) first_rise = cyc;
            end
            if (!i2c_start && start_q) last_dur = cyc - rise_cyc;
            if (host_ack) ack_cnt++;
            start_q = i2c_start;
        end
    end

    // I2C master model: level handshake, end after ACK_DLY cycles of start
    initial begin : master
        int mcnt;
        mcnt = 0;
        forever begin
            @(negedge clk_50);
            if (!reset_n || !i2c_start) begin
                i2c_end = 1'b0;
                i2c_nack = 1'b0;
                mcnt = 0;
            end else if (!i2c_end && !hang) begin
                mcnt++;
                if (mcnt >= ACK_DLY) begin
                    i2c_end = 1'b1;
                    i2c_nack = nack_en && (i2c_data == nack_word);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        first_rise = -1;
        ack_cnt = 0;
    endtask

    task automatic pulse_go();
        @(negedge clk_50);
        cfg_go = 1'b1;
        t0 = cyc;
        @(negedge clk_50);
        cfg_go = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_50);
        reset_n = 1'b0;
        repeat (n) @(negedge clk_50);
        reset_n = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_run(input string nm);
        int n;
        n = 0;
        while (!cfg_busy && n < 100) begin @(negedge clk_50); n++; end
        check({nm, "_busy_rise"}, 32'(cfg_busy), 32'd1);
        n = 0;
        while (cfg_busy && n < 20000) begin @(negedge clk_50); n++; end
        check({nm, "_busy_fall"}, 32'(cfg_busy), 32'd0);
        repeat (3) @(negedge clk_50);
    endtask

    task automatic host_write(input logic [23:0] d, output bit ok, output bit err);
        int n;
        @(negedge clk_50);
        host_data = d;
        host_req = 1'b1;
        n = 0;
        while (!host_ack && n < 3000) begin @(negedge clk_50); n++; end
        ok = host_ack;
        err = host_err;
        host_req = 1'b0;
    endtask

    initial begin
        sc[0] = '{"reset_run", 1'b1, 1'b0, 24'h000000, 1'b0, 11,          11, 1'b1, 1'b0, 10};
        sc[1] = '{"nack_w3",   1'b0, 1'b1, 24'h340217, 1'b0, NACK_STARTS, 4,  1'b0, 1'b1, 3};
        sc[2] = '{"timeout",   1'b0, 1'b0, 24'h000000, 1'b1, 1,           1,  1'b0, 1'b1, 0};
        sc[3] = '{"rerun",     1'b0, 1'b0, 24'h000000, 1'b0, 11,          11, 1'b1, 1'b0, 10};

        // Reset state
        repeat (3) @(negedge clk_50);
        check("reset_outputs",
              {i2c_data, i2c_start, host_ack, host_err, cfg_busy, cfg_done, cfg_error, 2'b00},
              32'd0);
        check("reset_idx", 32'(cfg_idx), 32'd0);

        // Scenario table
        for (int i = 0; i < 4; i++) begin
            hang = sc[i].hang;
            nack_en = sc[i].nack_en;
            nack_word = sc[i].nack_word;
            clear_log();
            if (sc[i].use_reset) do_reset(2);
            else pulse_go();
            wait_run(sc[i].name);
            check({sc[i].name, "_starts"}, log_q.size(), sc[i].exp_starts);
            check({sc[i].name, "_done"}, 32'(cfg_done), 32'(sc[i].exp_done));
            check({sc[i].name, "_error"}, 32'(cfg_error), 32'(sc[i].exp_err));
            check({sc[i].name, "_idx"}, 32'(cfg_idx), sc[i].exp_idx);
            for (int k = 0; k < sc[i].n_chk && k < log_q.size(); k++)
                check($sformatf("%s_word%0d", sc[i].name, k), 32'(log_q[k]), {8'h00, 8'h34, exp_rom[k]});
            if (sc[i].use_reset)
                check({sc[i].name, "_settle_lat"},
                      32'((first_rise - t0) >= SETTLE && (first_rise - t0) <= SETTLE + 4), 32'd1);
            else
                check({sc[i].name, "_go_lat"},
                      32'(first_rise > t0 && (first_rise - t0) <= 5), 32'd1);
            if (sc[i].hang) check("timeout_start_width", last_dur, TMO);
        end
        hang = 1'b0;
        nack_en = 1'b0;

        // Host write raised during table word 5
        begin
            int n;
            clear_log();
            pulse_go();
            n = 0;
            while (!(cfg_idx == 5'd5 && i2c_start) && n < 2000) begin @(negedge clk_50); n++; end
            check("host_mid_reach_w5", 32'(cfg_idx == 5'd5 && i2c_start), 32'd1);
            host_write(24'h341E00, h_ok, h_err);
            check("host_mid_ack", 32'(h_ok), 32'd1);
            check("host_mid_err", 32'(h_err), 32'd0);
            wait_run("host_mid");
            check("host_mid_starts", log_q.size(), 12);
            check("host_mid_w5", 32'(log_q[5]), 32'h340679);
            check("host_mid_host", 32'(log_q[6]), 32'h341E00);
            check("host_mid_w6", 32'(log_q[7]), 32'h340812);
            check("host_mid_w10", 32'(log_q[11]), 32'h341201);
            check("host_mid_ack_cnt", ack_cnt, 1);
            check("host_mid_done", 32'(cfg_done), 32'd1);
        end

        // Idle host write NACKed, then cfg_go re-runs without settle
        clear_log();
        nack_en = 1'b1;
        nack_word = 24'h1A2B3C;
        host_write(24'h1A2B3C, h_ok, h_err);
        check("host_idle_ack", 32'(h_ok), 32'd1);
        check("host_idle_err", 32'(h_err), 32'd1);
        repeat (2) @(negedge clk_50);
        check("host_idle_word", 32'(log_q[0]), 32'h1A2B3C);
        check("host_idle_ack_cnt", ack_cnt, 1);
        check("host_idle_done_kept", 32'(cfg_done), 32'd1);
        check("host_idle_busy", 32'(cfg_busy), 32'd0);
        nack_en = 1'b0;
        clear_log();
        pulse_go();
        wait_run("go_rerun");
        check("go_rerun_lat", 32'(first_rise > t0 && (first_rise - t0) <= 5), 32'd1);
        check("go_rerun_starts", log_q.size(), 11);
        check("go_rerun_word0", 32'(log_q[0]), 32'h341E00);
        check("go_rerun_done", 32'(cfg_done), 32'd1);

        // One-cycle reset while a table word is in WAIT
        begin
            int n;
            clear_log();
            pulse_go();
            n = 0;
            while (!(cfg_idx == 5'd2 && i2c_start) && n < 2000) begin @(negedge clk_50); n++; end
            check("rst_wait_reach", 32'(cfg_idx == 5'd2 && i2c_start), 32'd1);
            reset_n = 1'b0;
            @(negedge clk_50);
            check("rst_wait_start", 32'(i2c_start), 32'd0);
            check("rst_wait_flags", {28'd0, cfg_busy, cfg_done, cfg_error, host_ack}, 32'd0);
            check("rst_wait_idx", 32'(cfg_idx), 32'd0);
            reset_n = 1'b1;
            t0 = cyc;
            clear_log();
            wait_run("rst_restart");
            check("rst_restart_starts", log_q.size(), 11);
            check("rst_restart_done", 32'(cfg_done), 32'd1);
            check("rst_restart_settle", 32'((first_rise - t0) >= SETTLE), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
